dmem_lsu: RTL

Parametrised RV32I data memory with a built-in load/store unit. Supports byte, halfword and word accesses with sign/zero extension and misalignment and funct3 fault detection. A sequential clear engine zeroes the array after reset or on request. Optional registered read timing is provided. It sits between the core's execute stage and its data-side memory port. The async reset touches control state only, so the array can map to block RAM.

---
 rtl/dmem_lsu_if.sv | 41 ++++
 rtl/dmem_lsu.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the execute stage and the dmem_lsu data memory.
// Latency: none, this is only wiring.
// Backpressure: req_ready is driven by the memory side; the core holds a request until it is accepted.
//
// Signals:
//   clear_req   core -> mem  single-cycle pulse that restarts the zeroing sweep
//   req_valid   core -> mem  request present
//   req_ready   mem -> core  request can be accepted this cycle
//   req_we      core -> mem  1 = store, 0 = load
//   req_funct3  core -> mem  RV32I funct3 of the load/store
//   req_addr    core -> mem  byte address
//   req_wdata   core -> mem  store data, LSB-aligned
//   rsp_valid   mem -> core  one pulse per accepted request
//   rsp_rdata   mem -> core  extended load data (0 for stores and faults)
//   rsp_fault   mem -> core  accepted request was misaligned or had an illegal funct3
//   busy        mem -> core  clear sweep in progress
interface dmem_lsu_if;
  logic        clear_req;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        busy;

  // Core side.
  modport master (
    output clear_req, req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
  );

  // Memory side.
  modport slave (
    input  clear_req, req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
  );
endinterface

// File: rtl/dmem_lsu.sv
// RV32I data memory with a built-in load/store unit: byte/half/word access, sign/zero extension,
// misalignment and funct3 fault detection, and a sequential clear sweep that zeroes the array.
// Latency: response in the accept cycle (READ_REG=0) or one cycle after accept (READ_REG=1).
// Backpressure: req_ready is low while the sweep runs and in any cycle where clear_req is high.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset; resets control state only, never the array
//   bus    slave modport of dmem_lsu_if (request, response, clear_req and busy)
module dmem_lsu #(
  parameter int unsigned ADDR_W   = 8,    // word-address width, DEPTH = 2**ADDR_W words
  parameter bit          READ_REG = 1'b0  // 0 = combinational response, 1 = registered response
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_lsu_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // One response beat.
  typedef struct packed {
    logic        vld;
    logic [31:0] rdata;
    logic        fault;
  } rsp_t;

  // ---------------------------------------------------------------------------
  // Control FSM and sweep counter
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              sweep_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    if (bus.clear_req) begin
      // A clear request always restarts the sweep from word 0, even mid-sweep.
      state_d = ST_CLEAR;
      cnt_d   = '0;
    end else if (state_q == ST_CLEAR) begin
      sweep_we = 1'b1;
      cnt_d    = cnt_q + 1'b1;
      if (&cnt_q) begin
        state_d = ST_RUN;
      end
    end
  end

  assign bus.busy      = (state_q == ST_CLEAR);
  assign bus.req_ready = (state_q == ST_RUN) && !bus.clear_req;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic              accept;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        boff;
  logic              f3_legal;
  logic              misalign;
  logic              fault_c;
  logic              st_we;
  logic              unused_addr;

  assign accept = bus.req_valid && bus.req_ready;
  assign widx   = bus.req_addr[ADDR_W+1:2];
  assign boff   = bus.req_addr[1:0];

  // Upper address bits alias onto the array.
  assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

  always_comb begin
    f3_legal = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !bus.req_we;  // LBU/LHU have no store form
      default:                f3_legal = 1'b0;
    endcase

    // funct3[1:0] encodes the access size for every legal opcode.
    misalign = 1'b0;
    case (bus.req_funct3[1:0])
      2'b01:   misalign = boff[0];
      2'b10:   misalign = |boff;
      default: misalign = 1'b0;
    endcase
  end

  assign fault_c = !f3_legal || misalign;
  assign st_we   = accept && bus.req_we && !fault_c;

  // ---------------------------------------------------------------------------
  // Store lane steering
  // ---------------------------------------------------------------------------
  logic [3:0]  be;
  logic [31:0] wlane;

  always_comb begin
    be    = 4'b1111;
    wlane = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << boff;
        wlane = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be    = boff[1] ? 4'b1100 : 4'b0011;
        wlane = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = bus.req_wdata;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage array: no reset so it can map onto block RAM. The sweep and the
  // store path never write in the same cycle because req_ready is low in CLEAR.
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_q[cnt_q] <= '0;
    end else if (st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[widx][8*b +: 8] <= wlane[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction and extension
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;
  logic [31:0] byte_sh;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data;
  logic [31:0] rdata_c;

  assign rd_word  = mem_q[widx];
  assign byte_sh  = rd_word >> {boff, 3'b000};
  assign byte_sel = byte_sh[7:0];
  assign half_sel = boff[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = rd_word;
    case (bus.req_funct3)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ld_data = {24'h000000, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  ld_data = {16'h0000, half_sel};
      default: ld_data = rd_word;
    endcase
  end

  // Stores and faulting requests return zero data.
  assign rdata_c = (bus.req_we || fault_c) ? 32'h0 : ld_data;

  // ---------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------
  generate
    if (READ_REG) begin : g_rsp_reg
      rsp_t rsp_q, rsp_d;

      // Data and fault hold their last value between responses; the valid bit
      // is independent of clear_req so a captured response is still delivered.
      always_comb begin
        rsp_d     = rsp_q;
        rsp_d.vld = accept;
        if (accept) begin
          rsp_d.rdata = rdata_c;
          rsp_d.fault = fault_c;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rsp_q <= '0;
        end else begin
          rsp_q <= rsp_d;
        end
      end

      assign bus.rsp_valid = rsp_q.vld;
      assign bus.rsp_rdata = rsp_q.rdata;
      assign bus.rsp_fault = rsp_q.fault;
    end else begin : g_rsp_comb
      assign bus.rsp_valid = accept;
      assign bus.rsp_rdata = accept ? rdata_c : 32'h0;
      assign bus.rsp_fault = accept && fault_c;
    end
  endgenerate

endmodule
